// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register busy tracking for long-latency writes, RAW/WAW/capacity
// stalls and CSR serialisation. Optional stall counter enabled by SCOREBOARD_STALL_COUNTER_EN.
module issue_scoreboard #(
    parameter int MAX_PENDING     = 4,
    parameter int CSR_HOLD_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic [4:0]                       read_index_1,
    input  logic                             read_enable_1,
    input  logic [4:0]                       read_index_2,
    input  logic                             read_enable_2,
    input  logic [4:0]                       write_index,
    input  logic                             write_enable,
    input  logic                             long_latency,
    input  logic                             read_enable_csr,
    input  logic                             complete_valid,
    input  logic [4:0]                       complete_index,
    input  logic                             flush,
    output logic                             issue_ready,
    output logic [31:0]                      busy_vector,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
    output logic                             drain_active,
    output logic                             complete_error
`ifdef SCOREBOARD_STALL_COUNTER_EN
    ,
    output logic [31:0]                      stall_cycles
`endif
);

    localparam int CW = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   busy_reg, busy_next;
    logic [CW-1:0] count_reg, count_next;
    logic [2:0]    hold_reg, hold_next;
    logic          error_reg;
    logic          flush_window_reg;

    logic [31:0]   complete_mask, set_mask, eff_busy;
    logic [CW-1:0] eff_count;
    logic          hit, hazard, fire, set_busy, bad_complete;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_masks
            assign complete_mask[gi] = complete_valid && (complete_index == 5'(gi));
            assign set_mask[gi]      = set_busy && (write_index == 5'(gi));
        end
    endgenerate

    // A completion this cycle releases its register for the hazard check immediately.
    assign eff_busy  = busy_reg & ~complete_mask;
    assign hit       = complete_valid & busy_reg[complete_index];
    assign eff_count = count_reg - CW'(hit);

    assign hazard = (read_enable_1 & eff_busy[read_index_1])
                  | (read_enable_2 & eff_busy[read_index_2])
                  | (write_enable  & eff_busy[write_index])
                  | (long_latency & write_enable & (eff_count == CW'(MAX_PENDING)));

    assign issue_ready = ~reset & ~hazard & (state_reg == IDLE) & ~flush
                       & ~(read_enable_csr & (eff_count != '0));

    assign fire         = issue_valid & issue_ready;
    assign set_busy     = fire & long_latency & write_enable & (write_index != 5'd0);
    assign bad_complete = complete_valid & ~hit & ~flush_window_reg;

    // Clear before set so a same-index complete+issue leaves the bit set.
    assign busy_next  = (busy_reg & ~complete_mask) | set_mask;
    assign count_next = count_reg + CW'(set_busy) - CW'(hit);

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                if (fire & read_enable_csr) begin
                    state_next = HOLD;
                    hold_next  = 3'(CSR_HOLD_CYCLES);
                end else if (issue_valid & read_enable_csr & (eff_count != '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (eff_count == '0) state_next = IDLE;
            end
            HOLD: begin
                if (hold_reg <= 3'd1) state_next = IDLE;
                else                  hold_next  = hold_reg - 3'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            busy_reg         <= '0;
            count_reg        <= '0;
            hold_reg         <= '0;
            error_reg        <= 1'b0;
            flush_window_reg <= 1'b0;
        end else if (flush) begin
            state_reg        <= IDLE;
            busy_reg         <= '0;
            count_reg        <= '0;
            hold_reg         <= '0;
            error_reg        <= error_reg | bad_complete;
            flush_window_reg <= 1'b1;
        end else begin
            state_reg        <= state_next;
            busy_reg         <= busy_next;
            count_reg        <= count_next;
            hold_reg         <= hold_next;
            error_reg        <= error_reg | bad_complete;
            flush_window_reg <= 1'b0;
        end
    end

    assign busy_vector    = busy_reg;
    assign pending_count  = count_reg;
    assign drain_active   = (state_reg != IDLE);
    assign complete_error = error_reg;

`ifdef SCOREBOARD_STALL_COUNTER_EN
    logic [31:0] stall_reg;

    always_ff @(posedge clk) begin
        if (reset)
            stall_reg <= '0;
        else if (issue_valid & ~issue_ready & (stall_reg != 32'hFFFF_FFFF))
            stall_reg <= stall_reg + 32'd1;
    end

    assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: directed scenarios followed by random traffic,
// all checked against an array-based reference model of the scoreboard rules.
module tb_issue_scoreboard;

    localparam int MAXP = 4;
    localparam int HOLD = 1;

    logic        clk = 1'b0;
    logic        reset, issue_valid, read_enable_1, read_enable_2, write_enable;
    logic        long_latency, read_enable_csr, complete_valid, flush;
    logic [4:0]  read_index_1, read_index_2, write_index, complete_index;
    logic        issue_ready, drain_active, complete_error;
    logic [31:0] busy_vector;
    logic [2:0]  pending_count;
`ifdef SCOREBOARD_STALL_COUNTER_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    issue_scoreboard #(.MAX_PENDING(MAXP), .CSR_HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .read_index_1(read_index_1), .read_enable_1(read_enable_1),
        .read_index_2(read_index_2), .read_enable_2(read_enable_2),
        .write_index(write_index), .write_enable(write_enable),
        .long_latency(long_latency), .read_enable_csr(read_enable_csr),
        .complete_valid(complete_valid), .complete_index(complete_index),
        .flush(flush), .issue_ready(issue_ready), .busy_vector(busy_vector),
        .pending_count(pending_count), .drain_active(drain_active),
        .complete_error(complete_error)
`ifdef SCOREBOARD_STALL_COUNTER_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: busy set as a bit array, drain flag, remaining hold cycles.
    bit          mbusy[32];
    bit          mdrain, merr, msupp;
    int          mhold;
    logic [31:0] mstall;
    bit          m_rdy, m_hit;
    int          m_effcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    task automatic model_comb();
        bit effb[32];
        bit hz;
        m_hit    = complete_valid && mbusy[complete_index];
        m_effcnt = mcount() - int'(m_hit);
        for (int i = 0; i < 32; i++)
            effb[i] = mbusy[i] && !(complete_valid && complete_index == 5'(i));
        hz = (read_enable_1 && effb[read_index_1]) || (read_enable_2 && effb[read_index_2])
          || (write_enable && effb[write_index])
          || (long_latency && write_enable && m_effcnt == MAXP);
        m_rdy = !reset && !hz && !mdrain && mhold == 0 && !flush
             && !(read_enable_csr && m_effcnt != 0);
    endtask

    task automatic model_update();
        bit fire;
        if (reset) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            mdrain = 0; mhold = 0; merr = 0; msupp = 0; mstall = '0;
        end else begin
            if (issue_valid && !m_rdy && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
            if (complete_valid && !m_hit && !msupp) merr = 1;
            if (flush) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
                mdrain = 0; mhold = 0; msupp = 1;
            end else begin
                fire = issue_valid && m_rdy;
                if (m_hit) mbusy[complete_index] = 1'b0;
                if (fire && long_latency && write_enable && write_index != 0)
                    mbusy[write_index] = 1'b1;
                if (mdrain) begin
                    if (m_effcnt == 0) mdrain = 0;
                end else if (mhold > 0) begin
                    mhold--;
                end else if (fire && read_enable_csr) begin
                    mhold = HOLD;
                end else if (issue_valid && read_enable_csr && m_effcnt != 0) begin
                    mdrain = 1;
                end
                msupp = 0;
            end
        end
    endtask

    // Inputs are driven just after an edge; check settled values, then clock the model.
    task automatic do_cycle();
        logic [31:0] expbusy;
        #2;
        model_comb();
        for (int i = 0; i < 32; i++) expbusy[i] = mbusy[i];
        chk("issue_ready", issue_ready, m_rdy);
        chk("busy_vector", busy_vector, expbusy);
        chk("pending_count", pending_count, mcount());
        chk("drain_active", drain_active, mdrain || mhold > 0);
        chk("complete_error", complete_error, merr);
        chk("popcount", pending_count, $countones(busy_vector));
`ifdef SCOREBOARD_STALL_COUNTER_EN
        chk("stall_cycles", stall_cycles, mstall);
`endif
        $display("[TB] t=%0t rst=%0b iv=%0b csr=%0b cv=%0b/%0d fl=%0b ready=%0b busy=%h cnt=%0d drain=%0b err=%0b",
                 $time, reset, issue_valid, read_enable_csr, complete_valid, complete_index,
                 flush, issue_ready, busy_vector, pending_count, drain_active, complete_error);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        issue_valid = 0; read_index_1 = 0; read_enable_1 = 0; read_index_2 = 0;
        read_enable_2 = 0; write_index = 0; write_enable = 0; long_latency = 0;
        read_enable_csr = 0; complete_valid = 0; complete_index = 0; flush = 0;
    endtask

    task automatic load(input logic [4:0] rd);
        idle_in();
        issue_valid = 1; write_enable = 1; long_latency = 1; write_index = rd;
    endtask

    task automatic complete(input logic [4:0] idx);
        idle_in();
        complete_valid = 1; complete_index = idx;
    endtask

    initial begin
        idle_in();
        reset = 1;
        @(posedge clk);
        model_update();
        #1;
        do_cycle();
        reset = 0;

        // RAW hazard, released by a same-cycle completion
        load(5'd5);
        do_cycle();
        chk("raw_busy_set", busy_vector, 32'h20);
        chk("raw_count_set", pending_count, 1);
        for (int k = 0; k < 6; k++) begin
            idle_in();
            issue_valid = 1; read_enable_1 = 1; read_index_1 = 5'd5;
            write_enable = 1; write_index = 5'd10;
            #1 chk("raw_stall", issue_ready, 1'b0);
            do_cycle();
        end
        complete_valid = 1; complete_index = 5'd5;
        #1 chk("raw_bypass", issue_ready, 1'b1);
        do_cycle();
        chk("raw_busy_clear", busy_vector, 32'h0);
`ifdef SCOREBOARD_STALL_COUNTER_EN
        chk("stall_after_raw", stall_cycles, 32'd6);
`endif
        idle_in(); flush = 1;
        do_cycle();
`ifdef SCOREBOARD_STALL_COUNTER_EN
        chk("stall_after_flush", stall_cycles, 32'd6);
`endif

        // Capacity limit with a same-cycle completion freeing a slot
        for (int r = 1; r <= 4; r++) begin
            load(5'(r));
            do_cycle();
        end
        chk("cap_full", pending_count, 4);
        load(5'd6);
        #1 chk("cap_stall", issue_ready, 1'b0);
        do_cycle();
        load(5'd6); complete_valid = 1; complete_index = 5'd2;
        #1 chk("cap_bypass", issue_ready, 1'b1);
        do_cycle();
        chk("cap_count", pending_count, 4);
        chk("cap_busy", busy_vector, 32'h5A);
        complete(5'd1); do_cycle();
        complete(5'd3); do_cycle();
        complete(5'd4); do_cycle();
        complete(5'd6); do_cycle();

        // CSR drain, fire, then hold
        load(5'd7); do_cycle();
        load(5'd8); do_cycle();
        idle_in(); issue_valid = 1; read_enable_csr = 1; write_enable = 1; write_index = 5'd11;
        do_cycle();
        chk("csr_drain_active", drain_active, 1'b1);
        complete_valid = 1; complete_index = 5'd7; do_cycle();
        complete_valid = 1; complete_index = 5'd8;
        #1 chk("csr_drain_block", issue_ready, 1'b0);
        do_cycle();
        complete_valid = 0;
        #1 chk("csr_fire", issue_ready, 1'b1);
        do_cycle();
        idle_in(); issue_valid = 1; write_enable = 1; write_index = 5'd12;
        #1 chk("csr_hold_stall", issue_ready, 1'b0);
        do_cycle();
        #1 chk("csr_hold_done", issue_ready, 1'b1);
        do_cycle();

        // Same-index set and clear
        load(5'd9); do_cycle();
        load(5'd9); complete_valid = 1; complete_index = 5'd9;
        do_cycle();
        chk("setclr_busy", busy_vector, 32'h200);
        chk("setclr_count", pending_count, 1);
        complete(5'd9); do_cycle();

        // Flush during DRAIN, then completion suppression window
        load(5'd1); do_cycle();
        load(5'd2); do_cycle();
        load(5'd3); do_cycle();
        idle_in(); issue_valid = 1; read_enable_csr = 1; do_cycle();
        chk("flush_pre_drain", drain_active, 1'b1);
        idle_in(); flush = 1; do_cycle();
        chk("flush_busy", busy_vector, 32'h0);
        chk("flush_count", pending_count, 0);
        chk("flush_idle", drain_active, 1'b0);
        complete(5'd1); do_cycle();
        chk("flush_window_ignored", complete_error, 1'b0);
        complete(5'd2); do_cycle();
        chk("late_complete_error", complete_error, 1'b1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            reset           = ($urandom % 300) == 0;
            flush           = ($urandom % 60) == 0;
            issue_valid     = ($urandom % 4) != 0;
            read_index_1    = 5'($urandom_range(0, 7));
            read_enable_1   = 1'($urandom % 2);
            read_index_2    = 5'($urandom_range(0, 7));
            read_enable_2   = 1'($urandom % 2);
            write_index     = 5'($urandom_range(0, 7));
            write_enable    = (write_index != 0) && ($urandom % 4 != 0);
            long_latency    = 1'($urandom % 2);
            read_enable_csr = ($urandom % 12) == 0;
            complete_valid  = ($urandom % 3) == 0;
            complete_index  = 5'($urandom_range(0, 7));
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Sits between the instruction decoder and the execute stage.
- Tracks destination registers with outstanding long-latency writes (loads, multi-cycle mul/div) in a per-register busy vector.
- Stalls issue on RAW/WAW hazards against those registers, and on outstanding-write capacity.
- Serialises CSR instructions: drains all pending writes first, then holds issue for a fixed window after the CSR issues.

Parameters:
- MAX_PENDING, 4, maximum simultaneous outstanding long-latency writes (1..31).
- CSR_HOLD_CYCLES, 1, cycles issue is blocked after a CSR instruction fires (1..7).

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  decoded instruction present
- read_index_1  input  5  rs1 index
- read_enable_1  input  1  rs1 used
- read_index_2  input  5  rs2 index
- read_enable_2  input  1  rs2 used
- write_index  input  5  rd index
- write_enable  input  1  rd written (already 0 when rd==x0)
- long_latency  input  1  result returns later via completion port
- read_enable_csr  input  1  instruction is a CSR access
- complete_valid  input  1  long-latency result written back this cycle
- complete_index  input  5  register completed
- flush  input  1  pipeline flush (branch/trap)
- issue_ready  output  1  instruction may issue this cycle
- busy_vector  output  32  registered busy bits, bit 0 always 0
- pending_count  output  $clog2(MAX_PENDING+1)  outstanding long-latency writes
- drain_active  output  1  FSM in DRAIN or HOLD
- complete_error  output  1  sticky: completion received for a non-busy register

Behaviour:
- Reset (clk edge with reset=1):
  - busy_vector=0, pending_count=0, FSM=IDLE.
  - complete_error=0, issue_ready=0 (issue_ready is combinational; it is forced 0 while reset is asserted).
- Effective busy: eff_busy = busy_vector & ~(complete_valid ? onehot(complete_index) : 0). Completion bypasses the hazard check in the same cycle.
- Hazard = any of:
  - read_enable_1 & eff_busy[rs1]
  - read_enable_2 & eff_busy[rs2]
  - write_enable & eff_busy[rd]
  - long_latency & write_enable & (eff_count == MAX_PENDING)
- eff_count = pending_count minus 1 if a valid completion hits a busy bit.
- issue_ready is combinational. It is 1 only when all hold:
  - no hazard;
  - FSM==IDLE;
  - not (read_enable_csr & eff_count != 0);
  - flush=0.
- fire = issue_valid & issue_ready.
- On fire with long_latency & write_enable & rd!=0: set busy[rd] and increment the count.
- On completion of a busy register: clear its bit and decrement the count.
  - Both events on the same index in the same cycle: the bit ends set; the count is net unchanged.
- Completion for a non-busy register or x0: state unchanged, complete_error set (cleared only by reset).
- FSM:
  - IDLE: issue_valid & read_enable_csr & eff_count!=0 -> DRAIN. CSR fire -> HOLD with hold counter = CSR_HOLD_CYCLES.
  - DRAIN: issue blocked. When eff_count==0 -> IDLE; the CSR then fires in IDLE on the following cycle.
  - HOLD: issue blocked. The counter decrements each cycle; at 1 -> IDLE.
- Flush:
  - Next edge: busy_vector=0, count=0, FSM=IDLE.
  - complete_error is kept.
  - Completions that arrive after a flush target non-busy registers; they are ignored and do NOT set complete_error for 1 cycle after the flush edge. Late completions beyond that window do set it.
- Reset or flush mid-DRAIN/HOLD: the FSM returns to IDLE immediately.
- pending_count always equals popcount(busy_vector). A bench asserts this every cycle.

Optional Feature:
- Macro SCOREBOARD_STALL_COUNTER_EN.
- When defined:
  - Adds output stall_cycles [31:0].
  - Increments on every cycle with issue_valid & ~issue_ready, saturating at 0xFFFFFFFF.
  - Cleared by reset only, not by flush.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- RAW: issue long-latency load to x5 (fire) -> busy_vector=0x20, count=1. Next cycle an ADD reading x5 -> issue_ready=0. Completion x5 arrives -> ADD issues that same cycle; busy_vector=0 on the next edge.
- Capacity (MAX_PENDING=4): issue loads to x1..x4 -> count=4. A 5th load to x6 stalls. Completion x2 in the same cycle -> the 5th load fires; count stays 4 and busy_vector=0x5A.
- CSR drain: loads pending on x7,x8, then CSRRW -> DRAIN, drain_active=1. After both completions -> IDLE, CSR fires, HOLD for 1 cycle (next instruction stalls exactly 1 cycle), then IDLE.
- Simultaneous set/clear: x9 busy. Completion x9 while a new load to x9 fires -> bit 9 stays 1, count unchanged.
- Flush during DRAIN with 3 pending -> next cycle busy_vector=0, count=0, IDLE. A late completion 2 cycles later -> complete_error=1.
- With SCOREBOARD_STALL_COUNTER_EN: 6 stall cycles in the RAW test -> stall_cycles=6. A flush afterwards leaves it at 6.
